// File: rtl/sti_rx.sv
// rtl/sti_rx.sv - STI serial receiver: deserializes 8/16/24/32-bit words into a 16-bit payload
// Flags mid-word gaps and nonzero padding bits on po_err.
module sti_rx #(
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  input  logic              cfg_fill,
  input  logic              cfg_low,
  input  logic              si_data,
  input  logic              si_valid,
  output logic [15:0]       po_data,
  output logic              po_valid,
  output logic              po_err,
  output logic              busy,
  output logic [WCNT_W-1:0] word_cnt
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state, state_next;
  logic [1:0]  len_q;
  logic        msb_q, fill_q, low_q;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;

  logic        take_cfg;
  logic [1:0]  len_e;
  logic        msb_e, fill_e, low_e;
  logic [4:0]  cnt_base;
  logic [31:0] sh_base;
  logic [31:0] word_next;
  logic        last_bit;
  logic [15:0] dec_data;
  logic        dec_pad;

  // A config strobe in IDLE governs the word that may start in the same cycle.
  assign take_cfg = (state == IDLE) && cfg_load;
  assign len_e    = take_cfg ? cfg_length : len_q;
  assign msb_e    = take_cfg ? cfg_msb    : msb_q;
  assign fill_e   = take_cfg ? cfg_fill   : fill_q;
  assign low_e    = take_cfg ? cfg_low    : low_q;

  assign cnt_base = (state == IDLE) ? 5'd0  : bit_cnt;
  assign sh_base  = (state == IDLE) ? 32'd0 : shreg;
  assign last_bit = si_valid && (cnt_base == {len_e, 3'b111});
  assign busy     = (state == RECV);

  always_comb begin
    word_next = sh_base;
    if (msb_e) word_next = {sh_base[30:0], si_data};
    else       word_next = sh_base | ({31'd0, si_data} << cnt_base);
  end

  always_comb begin
    dec_data = 16'd0;
    dec_pad  = 1'b0;
    case (len_e)
      2'd0: dec_data = low_e ? {word_next[7:0], 8'd0} : {8'd0, word_next[7:0]};
      2'd1: dec_data = word_next[15:0];
      2'd2: begin
        dec_data = fill_e ? word_next[23:8] : word_next[15:0];
        dec_pad  = fill_e ? |word_next[7:0] : |word_next[23:16];
      end
      default: begin
        dec_data = fill_e ? word_next[31:16] : word_next[15:0];
        dec_pad  = fill_e ? |word_next[15:0] : |word_next[31:16];
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (si_valid) state_next = RECV;
      RECV: if (!si_valid || last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      po_data  <= 16'd0;
      po_valid <= 1'b0;
      po_err   <= 1'b0;
      word_cnt <= '0;
      bit_cnt  <= 5'd0;
      shreg    <= 32'd0;
      len_q    <= 2'd0;
      msb_q    <= 1'b1;
      fill_q   <= 1'b0;
      low_q    <= 1'b0;
    end else begin
      po_valid <= 1'b0;
      po_err   <= 1'b0;
      if (take_cfg) begin
        len_q  <= cfg_length;
        msb_q  <= cfg_msb;
        fill_q <= cfg_fill;
        low_q  <= cfg_low;
      end
      if (si_valid) begin
        if (last_bit) begin
          po_data  <= dec_data;
          po_valid <= 1'b1;
          po_err   <= dec_pad;
          word_cnt <= word_cnt + {{(WCNT_W-1){1'b0}}, 1'b1};
          bit_cnt  <= 5'd0;
          shreg    <= 32'd0;
        end else begin
          bit_cnt  <= cnt_base + 5'd1;
          shreg    <= word_next;
        end
      end else if (state == RECV) begin
        // Gap mid-word: drop the partial word, keep the last delivered payload.
        po_err  <= 1'b1;
        bit_cnt <= 5'd0;
        shreg   <= 32'd0;
      end
    end
  end

endmodule
